// File: rtl/fizzbuzz_pkg.sv
// Shared fizz/buzz tag encoding, entry layout and classification helper used by the
// classifier bench, the event queue and downstream formatters.
package fizzbuzz_pkg;

    localparam int FB_MAX_CYCLES = 100;
    localparam int FB_IDX_W      = $clog2(FB_MAX_CYCLES);

    localparam logic [1:0] FB_TAG_NUM      = 2'd0;
    localparam logic [1:0] FB_TAG_FIZZ     = 2'd1;
    localparam logic [1:0] FB_TAG_BUZZ     = 2'd2;
    localparam logic [1:0] FB_TAG_FIZZBUZZ = 2'd3;

    typedef enum logic [1:0] {
        TAG_NUM      = FB_TAG_NUM,
        TAG_FIZZ     = FB_TAG_FIZZ,
        TAG_BUZZ     = FB_TAG_BUZZ,
        TAG_FIZZBUZZ = FB_TAG_FIZZBUZZ
    } fb_tag_e;

    // Entry layout at the default classifier period; modules with another period
    // declare the same {idx, tag} shape at their own index width.
    typedef struct packed {
        logic [FB_IDX_W-1:0] idx;
        fb_tag_e             tag;
    } fb_entry_t;

    function automatic fb_tag_e fb_classify(input logic fizz, input logic buzz,
                                            input logic fizzbuzz);
        if (fizzbuzz || (fizz && buzz)) return TAG_FIZZBUZZ;
        if (fizz)                       return TAG_FIZZ;
        if (buzz)                       return TAG_BUZZ;
        return TAG_NUM;
    endfunction

endpackage

// File: rtl/fizzbuzz_event_queue_if.sv
// Flag-sample input and valid/ready event output of the fizz/buzz event queue.
interface fizzbuzz_event_queue_if
    import fizzbuzz_pkg::*;
#(
    parameter int MAX_CYCLES = FB_MAX_CYCLES
) ();

    localparam int IDX_W = $clog2(MAX_CYCLES);

    logic             in_valid;
    logic             fizz;
    logic             buzz;
    logic             fizzbuzz;
    logic             out_valid;
    logic             out_ready;
    fb_tag_e          out_tag;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, fizz, buzz, fizzbuzz, out_ready,
        input  out_valid, out_tag, out_idx
    );

    modport slave (
        input  in_valid, fizz, buzz, fizzbuzz, out_ready,
        output out_valid, out_tag, out_idx
    );

endinterface

// File: rtl/fizzbuzz_event_queue_fifo.sv
// fbq_fifo: generic synchronous FIFO with a registered head, so dout holds its last
// value when empty and never shows an unwritten slot.
module fbq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_nxt;
    logic             do_push, do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign wr_ptr_nxt = wr_ptr + (AW+1)'(do_push);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);

    // NOTE: every variable gets its default first so no path through the block
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        head_nxt = dout;
        if (rd_ptr_nxt != wr_ptr_nxt) begin
            // The new head is the slot being written this very cycle.
            if (rd_ptr_nxt == wr_ptr) head_nxt = din;
            else                      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
        end
    end

    // NOTE: the storage array is deliberately not reset; only slots between the
    // pointers are ever read, and a reset on the array would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            dout   <= head_nxt;
        end
    end

endmodule

// File: rtl/fizzbuzz_event_queue.sv
// Tags classifier flag samples with a wrapping sequence index and queues qualifying
// events for a valid/ready sink; define FBQ_NUM_PASS_EN to also queue NUM samples.
module fizzbuzz_event_queue
    import fizzbuzz_pkg::*;
#(
    parameter int MAX_CYCLES = FB_MAX_CYCLES,
    parameter int DEPTH      = 8,
    parameter int DROP_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    fizzbuzz_event_queue_if.slave  q_if,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int IDX_W = $clog2(MAX_CYCLES);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        fb_tag_e          tag;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [IDX_W-1:0]   idx_q;
    fb_tag_e            sample_tag;
    entry_t             push_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               push_req, pop, drop;
    logic               fifo_full, fifo_empty;

    assign sample_tag = fb_classify(q_if.fizz, q_if.buzz, q_if.fizzbuzz);
    assign push_entry = '{idx: idx_q, tag: sample_tag};

`ifdef FBQ_NUM_PASS_EN
    assign push_req = q_if.in_valid;
`else
    assign push_req = q_if.in_valid && (sample_tag != TAG_NUM);
`endif

    assign pop  = q_if.out_valid & q_if.out_ready;
    // A full queue only loses the sample when the sink is not freeing a slot.
    assign drop = push_req & fifo_full & ~pop;

    // The index counts every valid sample, queued or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else if (q_if.in_valid) begin
            idx_q <= (idx_q == IDX_W'(MAX_CYCLES - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    fbq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head           = entry_t'(fifo_dout);
    assign q_if.out_valid = ~fifo_empty;
    assign q_if.out_tag   = head.tag;
    assign q_if.out_idx   = head.idx;

endmodule

// File: tb/tb_fizzbuzz_event_queue.sv
// Self-checking bench for fizzbuzz_event_queue: queue-based reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_fizzbuzz_event_queue;
    import fizzbuzz_pkg::*;

    localparam int MAX_CYCLES = 100;
    localparam int DEPTH      = 8;
    localparam int DROP_W     = 8;
`ifdef FBQ_NUM_PASS_EN
    localparam bit NUM_PASS = 1'b1;
`else
    localparam bit NUM_PASS = 1'b0;
`endif

    typedef struct {
        int idx;
        int tag;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    fizzbuzz_event_queue_if #(.MAX_CYCLES(MAX_CYCLES)) bus ();

    fizzbuzz_event_queue #(
        .MAX_CYCLES (MAX_CYCLES),
        .DEPTH      (DEPTH),
        .DROP_W     (DROP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .q_if     (bus.slave),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  cmp_en   = 1'b0;

    ev_t mq[$];
    int  m_idx = 0, m_drops = 0, m_head_idx = 0, m_head_tag = 0;
    bit  m_ovf = 1'b0;
    int  last_pop_idx = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic int ref_class(input bit f, input bit b, input bit fb);
        if (fb || (f && b)) return 3;
        if (f) return 1;
        if (b) return 2;
        return 0;
    endfunction

    // Reference model: one transaction step using the inputs held across the edge.
    task automatic model_step();
        bit  pop, want;
        int  tag;
        ev_t e;
        if (reset) begin
            mq.delete();
            m_idx = 0; m_drops = 0; m_ovf = 1'b0; m_head_idx = 0; m_head_tag = 0;
            return;
        end
        pop  = (mq.size() > 0) && bus.out_ready;
        want = 1'b0;
        tag  = ref_class(bus.fizz, bus.buzz, bus.fizzbuzz);
        if (bus.in_valid) want = (tag != 0) || NUM_PASS;
        if (pop) void'(mq.pop_front());
        if (want) begin
            if (mq.size() < DEPTH) begin
                e.idx = m_idx; e.tag = tag;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < (1 << DROP_W) - 1) m_drops++;
            end
        end
        if (bus.in_valid) m_idx = (m_idx + 1) % MAX_CYCLES;
        if (mq.size() > 0) begin
            m_head_idx = mq[0].idx;
            m_head_tag = mq[0].tag;
        end
    endtask

    task automatic drive(input bit v, input bit f, input bit b, input bit fb, input bit rdy);
        bus.in_valid = v; bus.fizz = f; bus.buzz = b; bus.fizzbuzz = fb; bus.out_ready = rdy;
        if (bus.out_valid === 1'b1 && rdy) last_pop_idx = int'(bus.out_idx);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            check("model_out_tag",   32'(bus.out_tag),   32'(m_head_tag));
            check("model_out_idx",   32'(bus.out_idx),   32'(m_head_idx));
            check("model_overflow",  32'(overflow),      32'(m_ovf));
            check("model_drop_cnt",  32'(drop_cnt),      32'(m_drops));
        end
    end

    int  exp_tag[16] = '{3, 0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0, 0, 3};
    int  cnt, acc, guard;
    bit  v, ev;

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.fizz = 1'b0; bus.buzz = 1'b0; bus.fizzbuzz = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_tag",   32'(bus.out_tag),   0);
        check("reset_out_idx",   32'(bus.out_idx),   0);
        check("reset_drop_cnt",  32'(drop_cnt),      0);
        cmp_en = 1'b1;

        // Classifier sequence 0..15 with an always-ready sink.
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, (n % 3) == 0, (n % 5) == 0, (n % 15) == 0, 1'b1);
            ev = NUM_PASS || (exp_tag[n] != 0);
            check("seq_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) begin
                check("seq_tag", 32'(bus.out_tag), 32'(exp_tag[n]));
                check("seq_idx", 32'(bus.out_idx), 32'(n));
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("inconsistent_tag", 32'(bus.out_tag), 3);
        check("inconsistent_idx", 32'(bus.out_idx), 16);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow: 10 FIZZ into a stalled sink, then drain back-to-back.
        pulse_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drop_cnt", 32'(drop_cnt), 2);
        check("drain_head0", 32'(bus.out_idx), 0);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("drain_valid", 32'(bus.out_valid), 1);
            check("drain_idx", 32'(bus.out_idx), 32'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", 32'(bus.out_valid), 0);

        // Full queue with simultaneous push and pop for 20 cycles.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("full_pp_drop_cnt", 32'(drop_cnt), 2);
        cnt = 0;
        while (bus.out_valid === 1'b1 && cnt < 20) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cnt++;
        end
        check("full_pp_occupancy", 32'(cnt), 8);

        // Mid-stream reset with 5 queued entries and overflow set.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_reset_overflow", 32'(overflow), 1);
        pulse_reset();
        check("mid_reset_valid",    32'(bus.out_valid), 0);
        check("mid_reset_overflow", 32'(overflow), 0);
        check("mid_reset_drop_cnt", 32'(drop_cnt), 0);
        check("mid_reset_idx",      32'(bus.out_idx), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("post_reset_valid", 32'(bus.out_valid), 1);
        check("post_reset_idx",   32'(bus.out_idx), 0);
        check("post_reset_tag",   32'(bus.out_tag), 1);

        // 205 valid samples with toggling in_valid; the last one is a FIZZ.
        pulse_reset();
        acc = 0; guard = 0;
        while (acc < 205 && guard < 4000) begin
            v = (acc == 204) ? 1'b1 : 1'($urandom_range(0, 1));
            if (acc == 204) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            else drive(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b1);
            if (v) acc++;
            guard++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap_samples", 32'(acc), 205);
        check("wrap_last_idx", 32'(last_pop_idx), 4);
        check("wrap_model_idx", 32'(m_idx), 5);

        // Saturation of the drop counter.
        pulse_reset();
        for (int i = 0; i < 270; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_drop_cnt", 32'(drop_cnt), 255);

        // Random stress with a slow, bursty sink.
        pulse_reset();
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
